// File: rtl/apu_i2s_out.sv
// apu_i2s_out: APU audio back-end.
// Box-averages the 16-bit unsigned mixer stream by 2^ACC_SHIFT, converts the
// result to two's complement, buffers it in a small FIFO and serializes it as
// mono Philips I2S (same word on left and right).
//
// Ports:
//   clk          system clock, rising edge
//   rst_l        asynchronous active-low reset
//   enable       0 holds the block idle (sticky flags keep their value)
//   sample_en    one-cycle strobe qualifying audio_in
//   audio_in     16-bit unsigned mixer sample
//   clear_flags  one-cycle pulse clearing underrun/overflow
//   i2s_bclk     bit clock
//   i2s_lrclk    word select, 0 = left, 1 = right
//   i2s_sdata    serial data, MSB first
//   underrun     sticky: a frame started with the FIFO empty
//   overflow     sticky: a decimated sample was dropped on a full FIFO
module apu_i2s_out #(
   parameter int unsigned BCLK_DIV   = 4,
   parameter int unsigned ACC_SHIFT  = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        enable,
   input  logic        sample_en,
   input  logic [15:0] audio_in,
   input  logic        clear_flags,
   output logic        i2s_bclk,
   output logic        i2s_lrclk,
   output logic        i2s_sdata,
   output logic        underrun,
   output logic        overflow
);

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned ACC_W    = SAMPLE_W + ACC_SHIFT;
   localparam int unsigned CNT_W    = (ACC_SHIFT > 0) ? ACC_SHIFT : 1;
   localparam int unsigned CNT_MAX  = (1 << ACC_SHIFT) - 1;
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned PTRX_W   = PTR_W + 1;
   localparam int unsigned DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   // ---------------------------------------------------------------- decimator
   logic [ACC_W-1:0]    r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_push;
   logic [SAMPLE_W-1:0] r_push_data;

   logic [ACC_W-1:0]    w_sum;
   logic [SAMPLE_W-1:0] w_avg;
   logic                w_last_in;

   assign w_sum     = r_acc + ACC_W'(audio_in);
   assign w_avg     = w_sum[ACC_SHIFT +: SAMPLE_W];
   assign w_last_in = (r_cnt == CNT_W'(CNT_MAX));

   // Accumulate; on the last sample of a group register the truncated average
   // (MSB flipped to signed) so the FIFO write lands on the following cycle.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
      end else if (!enable) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
      end else begin
         r_push <= 1'b0;
         if (sample_en) begin
            if (w_last_in) begin
               r_acc       <= '0;
               r_cnt       <= '0;
               r_push      <= 1'b1;
               r_push_data <= {~w_avg[SAMPLE_W-1], w_avg[SAMPLE_W-2:0]};
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   // --------------------------------------------------------------------- FIFO
   logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTRX_W-1:0]   r_wr_ptr;
   logic [PTRX_W-1:0]   r_rd_ptr;

   logic                w_empty;
   logic                w_full;
   logic                w_frame_start;
   logic                w_do_pop;
   logic                w_do_push;
   logic                w_set_ovf;
   logic                w_set_udr;
   logic [SAMPLE_W-1:0] w_head;

   // Extra pointer bit distinguishes full from empty.
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign w_do_pop  = w_frame_start & ~w_empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign w_do_push = enable & r_push & (~w_full | w_do_pop);
   assign w_set_ovf = enable & r_push & w_full & ~w_do_pop;
   assign w_set_udr = w_frame_start & w_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= r_push_data;
      end
   end

   // Pointers plus sticky flags; a set event beats a simultaneous clear.
   logic r_underrun;
   logic r_overflow;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_underrun <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (!enable) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTRX_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTRX_W'(1);
         end
         r_underrun <= (r_underrun & ~clear_flags) | w_set_udr;
         r_overflow <= (r_overflow & ~clear_flags) | w_set_ovf;
      end
   end

   // --------------------------------------------------------------- serializer
   logic [DIV_W-1:0]    r_div;
   logic                r_bclk;
   logic [5:0]          r_bitcnt;
   logic                r_lrclk;
   logic                r_sdata;
   logic [SAMPLE_W-1:0] r_last;

   logic                w_div_wrap;
   logic                w_fall;
   logic [5:0]          w_next_cnt;
   logic [4:0]          w_pos;
   logic [3:0]          w_bit_idx;
   logic                w_sdata_next;

   assign w_div_wrap    = (r_div == DIV_W'(BCLK_DIV - 1));
   assign w_fall        = enable & w_div_wrap & r_bclk;
   assign w_frame_start = w_fall & (r_bitcnt == 6'd63);
   assign w_next_cnt    = r_bitcnt + 6'd1;
   assign w_pos         = w_next_cnt[4:0];
   assign w_bit_idx     = 4'(5'd16 - w_pos);
   // Slot 0 is the I2S one-bit delay; slots 1..16 carry the word MSB first.
   assign w_sdata_next  = (w_pos >= 5'd1 && w_pos <= 5'd16) ? r_last[w_bit_idx] : 1'b0;

   // BCLK divider and bit counter; every serial output moves on a BCLK fall.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_div    <= '0;
         r_bclk   <= 1'b0;
         r_bitcnt <= '0;
         r_lrclk  <= 1'b0;
         r_sdata  <= 1'b0;
         r_last   <= '0;
      end else if (!enable) begin
         r_div    <= '0;
         r_bclk   <= 1'b0;
         r_bitcnt <= '0;
         r_lrclk  <= 1'b0;
         r_sdata  <= 1'b0;
         r_last   <= '0;
      end else begin
         if (w_div_wrap) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
         if (w_fall) begin
            r_bitcnt <= w_next_cnt;
            r_lrclk  <= w_next_cnt[5];
            r_sdata  <= w_sdata_next;
            // On underrun the previous word is simply kept.
            if (w_do_pop) r_last <= w_head;
         end
      end
   end

   assign i2s_bclk  = r_bclk;
   assign i2s_lrclk = r_lrclk;
   assign i2s_sdata = r_sdata;
   assign underrun  = r_underrun;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_apu_i2s_out.sv
// tb_apu_i2s_out: directed self-checking bench for apu_i2s_out.
// Instance A: BCLK_DIV=1, ACC_SHIFT=2, FIFO_DEPTH=4 (decimation, framing, flags).
// Instance B: BCLK_DIV=2, ACC_SHIFT=0, FIFO_DEPTH=4 (overflow, divider timing).
module tb_apu_i2s_out;

   logic        clk;
   logic        rst_l;
   logic        en_a, sen_a, clr_a;
   logic [15:0] din_a;
   logic        bclk_a, lr_a, sd_a, und_a, ovf_a;
   logic        en_b, sen_b, clr_b;
   logic [15:0] din_b;
   logic        bclk_b, lr_b, sd_b, und_b, ovf_b;

   int n_checks;
   int n_fail;

   apu_i2s_out #(.BCLK_DIV(1), .ACC_SHIFT(2), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .rst_l(rst_l), .enable(en_a), .sample_en(sen_a), .audio_in(din_a),
      .clear_flags(clr_a), .i2s_bclk(bclk_a), .i2s_lrclk(lr_a), .i2s_sdata(sd_a),
      .underrun(und_a), .overflow(ovf_a));

   apu_i2s_out #(.BCLK_DIV(2), .ACC_SHIFT(0), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .rst_l(rst_l), .enable(en_b), .sample_en(sen_b), .audio_in(din_b),
      .clear_flags(clr_b), .i2s_bclk(bclk_b), .i2s_lrclk(lr_b), .i2s_sdata(sd_b),
      .underrun(und_b), .overflow(ovf_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic logic get_lr(input bit w);
      return w ? lr_b : lr_a;
   endfunction
   function automatic logic get_bclk(input bit w);
      return w ? bclk_b : bclk_a;
   endfunction
   function automatic logic get_sd(input bit w);
      return w ? sd_b : sd_a;
   endfunction

   // Expected 64-slot frame, slot 0 in bit 63.
   function automatic logic [63:0] frame_of(input logic [15:0] s);
      return {1'b0, s, 15'h0000, 1'b0, s, 15'h0000};
   endfunction

   task automatic pulse(input bit w, input logic [15:0] v);
      @(negedge clk);
      if (w) begin sen_b = 1'b1; din_b = v; end
      else   begin sen_a = 1'b1; din_a = v; end
      @(negedge clk);
      sen_a = 1'b0;
      sen_b = 1'b0;
   endtask

   task automatic send4(input logic [15:0] v);
      repeat (4) pulse(1'b0, v);
   endtask

   task automatic pulse_clear(input bit w);
      @(negedge clk);
      if (w) clr_b = 1'b1; else clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      clr_b = 1'b0;
   endtask

   task automatic wait_frame_start(input bit w);
      logic pl, cl;
      bit   found;
      found = 1'b0;
      pl    = get_lr(w);
      for (int n = 0; n < 700 && !found; n++) begin
         @(negedge clk);
         cl = get_lr(w);
         if (pl && !cl) found = 1'b1;
         pl = cl;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL frame_start_wait: no lrclk fall within 700 cycles, required one");
      end
   endtask

   // Waits for the next lrclk fall and records sdata/lrclk on all 64 BCLK falls.
   task automatic capture_frame(input bit w, output logic [63:0] sd,
                                output logic [63:0] lr, output bit ok);
      logic pl, cl, pb, cb;
      bit   found;
      int   slot;
      sd = '0; lr = '0; found = 1'b0; slot = 0;
      pl = get_lr(w);
      for (int n = 0; n < 700 && !found; n++) begin
         @(negedge clk);
         cl = get_lr(w);
         if (pl && !cl) found = 1'b1;
         pl = cl;
      end
      if (found) begin
         sd[63] = get_sd(w);
         lr[63] = get_lr(w);
         slot   = 1;
         pb     = get_bclk(w);
         for (int n = 0; n < 700 && slot < 64; n++) begin
            @(negedge clk);
            cb = get_bclk(w);
            if (pb && !cb) begin
               sd[63-slot] = get_sd(w);
               lr[63-slot] = get_lr(w);
               slot++;
            end
            pb = cb;
         end
      end
      ok = (slot == 64);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bclk_a, lr_a, sd_a, und_a, ovf_a} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_outputs_a: got %b, required 00000", {bclk_a, lr_a, sd_a, und_a, ovf_a});
      end
      n_checks++;
      if ({bclk_b, lr_b, sd_b, und_b, ovf_b} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_outputs_b: got %b, required 00000", {bclk_b, lr_b, sd_b, und_b, ovf_b});
      end
      rst_l = 1'b1;
      en_a  = 1'b1;
      en_b  = 1'b1;
   endtask

   task automatic test_underrun();
      logic [63:0] sd, lr;
      bit ok;
      capture_frame(1'b0, sd, lr, ok);
      n_checks++;
      if (!ok || sd !== frame_of(16'h0000)) begin
         n_fail++;
         $display("FAIL underrun_first_frame: got %h ok=%0d, required %h", sd, ok, frame_of(16'h0000));
      end
      n_checks++;
      if (und_a !== 1'b1) begin
         n_fail++;
         $display("FAIL underrun_set: got %b, required 1", und_a);
      end
      wait_frame_start(1'b0);
      pulse_clear(1'b0);
      n_checks++;
      if (und_a !== 1'b0) begin
         n_fail++;
         $display("FAIL underrun_clear: got %b, required 0", und_a);
      end
      send4(16'h9234);
      capture_frame(1'b0, sd, lr, ok);
      n_checks++;
      if (!ok || sd !== frame_of(16'h1234)) begin
         n_fail++;
         $display("FAIL underrun_refill_frame: got %h ok=%0d, required %h", sd, ok, frame_of(16'h1234));
      end
      n_checks++;
      if (und_a !== 1'b0) begin
         n_fail++;
         $display("FAIL underrun_no_event: got %b, required 0", und_a);
      end
      capture_frame(1'b0, sd, lr, ok);
      n_checks++;
      if (!ok || sd !== frame_of(16'h1234)) begin
         n_fail++;
         $display("FAIL underrun_repeat_frame: got %h ok=%0d, required %h", sd, ok, frame_of(16'h1234));
      end
      n_checks++;
      if (und_a !== 1'b1) begin
         n_fail++;
         $display("FAIL underrun_reset_again: got %b, required 1", und_a);
      end
   endtask

   task automatic test_decimation();
      logic [63:0] sd, lr;
      bit ok;
      logic [15:0] exp_w [3];
      exp_w[0] = 16'h80FA;   // (100+200+300+400)/4 = 250
      exp_w[1] = 16'h8001;   // 5/4 truncates to 1
      exp_w[2] = 16'h7FFF;   // full-scale input, needs the widened accumulator
      wait_frame_start(1'b0);
      pulse(1'b0, 16'd100); pulse(1'b0, 16'd200); pulse(1'b0, 16'd300); pulse(1'b0, 16'd400);
      pulse(1'b0, 16'd1);   pulse(1'b0, 16'd1);   pulse(1'b0, 16'd1);   pulse(1'b0, 16'd2);
      send4(16'hFFFF);
      for (int i = 0; i < 3; i++) begin
         capture_frame(1'b0, sd, lr, ok);
         n_checks++;
         if (!ok || sd !== frame_of(exp_w[i])) begin
            n_fail++;
            $display("FAIL decimation_%0d: got %h ok=%0d, required %h", i, sd, ok, frame_of(exp_w[i]));
         end
      end
   endtask

   task automatic test_framing();
      logic [63:0] sd, lr;
      bit ok;
      wait_frame_start(1'b0);
      send4(16'h25C3);
      capture_frame(1'b0, sd, lr, ok);
      n_checks++;
      if (!ok || sd !== 64'h52E1_8000_52E1_8000) begin
         n_fail++;
         $display("FAIL framing_sdata: got %h ok=%0d, required 52e1800052e18000", sd, ok);
      end
      n_checks++;
      if (lr !== 64'h0000_0000_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL framing_lrclk: got %h, required 00000000ffffffff", lr);
      end
   endtask

   // Fifth push lands on the very cycle the frame start pops a full FIFO.
   task automatic test_back_to_back();
      logic [63:0] sd, lr;
      bit ok;
      logic [15:0] vin [5];
      logic [15:0] vout [5];
      for (int i = 0; i < 5; i++) begin
         vin[i]  = 16'h8000 | 16'((i + 1) * 16'h0111);
         vout[i] = 16'((i + 1) * 16'h0111);
      end
      pulse_clear(1'b0);
      wait_frame_start(1'b0);                 // frame start was 0.5 cycle ago
      for (int i = 0; i < 4; i++) send4(vin[i]);
      repeat (3) pulse(1'b0, vin[4]);         // 38 negedges elapsed
      repeat (87) @(negedge clk);
      pulse(1'b0, vin[4]);                    // sampled 127 cycles after frame start
      for (int i = 0; i < 5; i++) begin
         capture_frame(1'b0, sd, lr, ok);
         n_checks++;
         if (!ok || sd !== frame_of(vout[i])) begin
            n_fail++;
            $display("FAIL back_to_back_frame_%0d: got %h ok=%0d, required %h", i, sd, ok, frame_of(vout[i]));
         end
         if (i == 0) begin
            n_checks++;
            if (ovf_a !== 1'b0) begin
               n_fail++;
               $display("FAIL back_to_back_overflow: got %b, required 0", ovf_a);
            end
         end
      end
      capture_frame(1'b0, sd, lr, ok);
      n_checks++;
      if (!ok || sd !== frame_of(vout[4]) || und_a !== 1'b1) begin
         n_fail++;
         $display("FAIL back_to_back_drain: got %h und=%b, required %h und=1", sd, und_a, frame_of(vout[4]));
      end
   endtask

   task automatic test_clear_vs_set();
      wait_frame_start(1'b0);
      repeat (127) @(negedge clk);
      clr_a = 1'b1;                           // sampled on the frame-start edge
      @(negedge clk);
      clr_a = 1'b0;
      n_checks++;
      if (und_a !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_vs_underrun: got %b, required 1", und_a);
      end
      pulse_clear(1'b0);
      n_checks++;
      if (und_a !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_quiet: got %b, required 0", und_a);
      end
   endtask

   task automatic test_overflow();
      logic [63:0] sd, lr;
      bit ok;
      pulse_clear(1'b1);
      wait_frame_start(1'b1);
      for (int i = 1; i <= 4; i++) pulse(1'b1, 16'h8000 | 16'(i));
      @(negedge clk);
      n_checks++;
      if (ovf_b !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_early: got %b, required 0", ovf_b);
      end
      pulse(1'b1, 16'h8005);
      @(negedge clk);
      n_checks++;
      if (ovf_b !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_set: got %b, required 1", ovf_b);
      end
      for (int i = 1; i <= 5; i++) begin
         capture_frame(1'b1, sd, lr, ok);
         n_checks++;
         // Fifth sample was dropped; the last frame repeats sample 4.
         if (!ok || sd !== frame_of(16'((i > 4) ? 4 : i))) begin
            n_fail++;
            $display("FAIL overflow_frame_%0d: got %h ok=%0d, required %h", i, sd, ok, frame_of(16'((i > 4) ? 4 : i)));
         end
      end
   endtask

   task automatic test_enable();
      int   ta, tb, fa, ra;
      logic pa, pb;
      bit   sd_seen;
      wait_frame_start(1'b0);
      @(negedge clk);
      en_a = 1'b0;
      en_b = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bclk_a, lr_a, sd_a, bclk_b, lr_b, sd_b} !== 6'b000000) begin
         n_fail++;
         $display("FAIL idle_outputs: got %b, required 000000", {bclk_a, lr_a, sd_a, bclk_b, lr_b, sd_b});
      end
      n_checks++;
      if ({und_a, ovf_b} !== 2'b11) begin
         n_fail++;
         $display("FAIL idle_flags_hold: got %b, required 11", {und_a, ovf_b});
      end
      en_a = 1'b1;
      en_b = 1'b1;
      ta = 0; tb = 0; fa = 0; ra = 0; pa = 1'b0; pb = 1'b0; sd_seen = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (pa && !bclk_a) begin
            fa++;
            if (ta == 0) ta = k;
         end
         if (pb && !bclk_b && tb == 0) tb = k;
         if (lr_a && ra == 0) ra = fa;
         if (sd_a) sd_seen = 1'b1;
         pa = bclk_a;
         pb = bclk_b;
      end
      n_checks++;
      if (ta != 2) begin
         n_fail++;
         $display("FAIL enable_first_fall_a: got %0d cycles, required 2", ta);
      end
      n_checks++;
      if (tb != 4) begin
         n_fail++;
         $display("FAIL enable_first_fall_b: got %0d cycles, required 4", tb);
      end
      n_checks++;
      if (ra != 32) begin
         n_fail++;
         $display("FAIL enable_left_length: lrclk rose at fall %0d, required 32", ra);
      end
      n_checks++;
      if (sd_seen) begin
         n_fail++;
         $display("FAIL enable_sdata_quiet: got sdata 1 before first frame, required 0");
      end
   endtask

   task automatic test_reset_midframe();
      bit found;
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         @(negedge clk);
         if (bclk_a && lr_a) found = 1'b1;
      end
      n_checks++;
      if (!found || {und_a, ovf_b} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_precondition: found=%0d flags=%b, required found=1 flags=11", found, {und_a, ovf_b});
      end
      #1;
      rst_l = 1'b0;
      #1;
      n_checks++;
      if ({bclk_a, lr_a, sd_a, und_a, ovf_a, bclk_b, lr_b, sd_b, und_b, ovf_b} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_async: got %b, required 0000000000",
                  {bclk_a, lr_a, sd_a, und_a, ovf_a, bclk_b, lr_b, sd_b, und_b, ovf_b});
      end
      @(negedge clk);
      rst_l = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_l = 1'b0;
      en_a = 1'b0; sen_a = 1'b0; clr_a = 1'b0; din_a = 16'h0000;
      en_b = 1'b0; sen_b = 1'b0; clr_b = 1'b0; din_b = 16'h0000;
      test_reset();
      test_underrun();
      test_decimation();
      test_framing();
      test_back_to_back();
      test_clear_vs_set();
      test_overflow();
      test_enable();
      test_reset_midframe();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apu_i2s_out.md
# apu_i2s_out

Audio back-end for the APU. It consumes the 16-bit mixer sample stream that the APU produces at the APU sample rate and decimates it by a power-of-two box average. Decimated samples are buffered in a small FIFO and serialized as a standard Philips I2S stream (mono, duplicated on left and right) for the board codec. Underrun and overflow are reported as sticky flags for the debug register file.

## Interface

Parameters:
- BCLK_DIV, default 4: clk cycles per BCLK half-period; legal range ≥1.
- ACC_SHIFT, default 3: decimation factor is 2^ACC_SHIFT input samples per output sample; legal range 0–6.
- FIFO_DEPTH, default 4: FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_l  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  block enable. When 0, the block is held in its idle state.
- sample_en  in  1  one-cycle strobe marking that audio_in is valid (the APU clock enable).
- audio_in  in  16  unsigned mixer output.
- clear_flags  in  1  one-cycle pulse that clears both sticky flags.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first, two's complement.
- underrun  out  1  sticky flag: a frame started with the FIFO empty.
- overflow  out  1  sticky flag: a decimated sample was dropped because the FIFO was full.

## Operation

Reset state (rst_l low):
- i2s_bclk, i2s_lrclk, i2s_sdata, underrun and overflow all 0.
- Accumulator, sample count, FIFO pointers, bit counter, BCLK divider and last-sample register all 0.

Idle (enable = 0):
- Same state as reset, except the sticky flags hold their values.
- Leaving idle restarts framing at bit 0 of a left word.

Decimator:
- Accumulator width is 16+ACC_SHIFT bits.
- Sample counter width is ACC_SHIFT bits, or none when ACC_SHIFT = 0.
- On each sample_en: add audio_in to the accumulator.
- When sample_en arrives with count = 2^ACC_SHIFT−1:
  - Push (acc+audio_in)>>ACC_SHIFT, with MSB inverted (unsigned→signed), to the FIFO.
  - Clear the accumulator and the count.
- Truncation only; no rounding.

FIFO:
- Synchronous, FIFO_DEPTH entries, with a separate full/empty flag or an extra pointer bit.
- Push when full and no pop in the same cycle: the sample is dropped and overflow is set.
- Push and pop in the same cycle both take effect, including when the FIFO is full.
- Pop when empty: no pointer change, underrun is set, and the last-sample register is reused.
  - A simultaneous push in that cycle still writes.

Serializer:
- BCLK divider counts 0..BCLK_DIV−1; i2s_bclk toggles on wrap.
- Bit counter (6 bits, 0–63) advances when i2s_bclk goes 1→0 (falling edge). All outputs update on that edge.
- i2s_lrclk = bit counter bit 5.
- Frame start is the falling edge where the counter wraps 63→0:
  - Pop the FIFO, or reuse last on empty.
  - Load last-sample and shift register.
- Within each 32-bit half, slot position p = counter[4:0]:
  - p = 0: sdata = 0 (I2S one-bit delay).
  - p = 1–16: sample bits 15..0.
  - p = 17–31: 0.
- The same sample is sent in the right half.

Flags:
- clear_flags clears both flags.
- A set event in the same cycle as clear_flags wins; the flag reads 1.

## Timing

- Output rate is clk / (128·BCLK_DIV) frames per second. The input average rate must not exceed this.
- Decimation latency: the push occurs in the cycle after the final sample_en.
- Serializer latency: the FIFO head is consumed at the next frame start. Its MSB appears on sdata one BCLK period after i2s_lrclk falls.
- First BCLK falling edge after reset or enable: 2·BCLK_DIV clk cycles. The first frame start occurs at the 64th falling edge; before that, sdata is 0.
- After rst_l deasserts, all registers leave reset on the first rising clk edge.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronously) and the partial frame is discarded.
- sample_en pulses closer together than one cycle are not supported. sample_en is ignored while enable = 0.

## Test plan

- **Decimation.** BCLK_DIV=1, ACC_SHIFT=2; feed 100, 200, 300, 400 → FIFO receives 250 with MSB flipped = 16'h80FA; the next frame shows 16'h80FA in both the left and right slots.
- **Framing.** FIFO holds 16'hA5C3 → i2s_lrclk falls and sdata is 0 for one BCLK. The next 16 bits are 1010010111000011, followed by 15 zeros; the right half repeats the pattern.
- **Underrun.** No input after reset → frames carry 16'h0000, underrun = 1. clear_flags → 0. Then push 16'h1234 → the next frame carries 16'h1234, and later frames repeat it while the FIFO is empty.
- **Overflow.** ACC_SHIFT=0, FIFO_DEPTH=4, enable=1, five sample_en pulses within one frame → the 5th sample is dropped and overflow = 1. The next four frames output samples 1–4 in order.
- **Simultaneous events.** Push coincides with a frame-start pop while the FIFO is full → no overflow and the count stays at 4. clear_flags coincides with an underrun event → underrun reads 1.
- **Reset and enable.** Assert rst_l low mid-frame → bclk, lrclk, sdata and flags are 0 on the same cycle. Toggle enable 0→1 → the first falling BCLK edge comes after 2·BCLK_DIV cycles, and lrclk stays low for 32 BCLKs.
